score_keeper: RTL and testbench

Produces the 16-bit binary score that the 7-segment display stage converts and multiplexes, which shows three decimal digits. It accepts single-cycle game-event pulses and queues them per event type. It applies one queued event per cycle as a saturating addition, awards streak bonuses, and pulses an extra-life strobe each time the score crosses a life threshold.

---
 rtl/score_pkg.sv | 31 +++
 rtl/score_event_queue.sv | 94 +++++++++
 rtl/score_keeper.sv | 155 +++++++++++++++
 tb/tb_score_keeper.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : score_pkg
//  Purpose : Shared constants and types for the score keeper: default point
//            values, streak / life / saturation defaults, score width and the
//            event-type encoding used between the queue and the score path.
//  Ports   : none (package)
//  Revision: 1.0 - initial release
// ============================================================================
package score_pkg;

    localparam int SCORE_W        = 16;

    localparam int PTS_GEM_DEF    = 1;
    localparam int PTS_GOLD_DEF   = 5;
    localparam int PTS_ENEMY_DEF  = 10;
    localparam int PTS_STREAK_DEF = 20;
    localparam int STREAK_LEN_DEF = 8;
    localparam int LIFE_STEP_DEF  = 100;
    localparam int MAX_SCORE_DEF  = 999;

    typedef enum logic [2:0] {
        EV_NONE  = 3'd0,
        EV_GEM   = 3'd1,
        EV_GOLD  = 3'd2,
        EV_ENEMY = 3'd3,
        EV_BONUS = 3'd4
    } ev_type_t;

endpackage : score_pkg
`default_nettype wire

// File: rtl/score_event_queue.sv
`default_nettype none
// ============================================================================
//  Module  : score_event_queue
//  Purpose : Per-type 2-bit saturating pending counters for gem, gold and
//            enemy events, the sticky lost flag, and a fixed-priority arbiter
//            (bonus > enemy > gold > gem) issuing one grant per cycle.
//  Ports   : clk, rst_n (sync, active low), new_game (sync clear)
//            ev_gem / ev_gold / ev_enemy  - event pulses
//            bonus_pending                - streak bonus flag from the score path
//            grant                        - event type granted this cycle
//            pend_next_any                - any counter non-zero after this edge
//            lost                         - sticky, a pulse was dropped
//  Revision: 1.0 - initial release
// ============================================================================
module score_event_queue
    import score_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     new_game,
    input  logic     ev_gem,
    input  logic     ev_gold,
    input  logic     ev_enemy,
    input  logic     bonus_pending,
    output ev_type_t grant,
    output logic     pend_next_any,
    output logic     lost
);

    // Slot order: [0] gem, [1] gold, [2] enemy
    logic [2:0][1:0] r_cnt;
    logic [2:0][1:0] w_cnt_next;
    logic [2:0]      w_ev;
    logic [2:0]      w_dec;
    logic [2:0]      w_drop;
    logic            r_lost;

    assign w_ev = {ev_enemy, ev_gold, ev_gem};

    // Arbiter works purely from registered state, so the grant never
    // depends combinationally on an event pulse arriving this cycle.
    always_comb begin
        grant = EV_NONE;
        w_dec = 3'b000;
        if (bonus_pending) begin
            grant = EV_BONUS;
        end else if (r_cnt[2] != 2'd0) begin
            grant    = EV_ENEMY;
            w_dec[2] = 1'b1;
        end else if (r_cnt[1] != 2'd0) begin
            grant    = EV_GOLD;
            w_dec[1] = 1'b1;
        end else if (r_cnt[0] != 2'd0) begin
            grant    = EV_GEM;
            w_dec[0] = 1'b1;
        end
    end

    // A pulse that coincides with a grant of the same type is a net-zero
    // change and is accepted even at count 3; only a pulse into a full
    // counter that is not draining this cycle is dropped.
    always_comb begin
        w_cnt_next = r_cnt;
        w_drop     = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (w_ev[i] && !w_dec[i]) begin
                if (r_cnt[i] == 2'd3) begin
                    w_drop[i] = 1'b1;
                end else begin
                    w_cnt_next[i] = r_cnt[i] + 2'd1;
                end
            end else if (!w_ev[i] && w_dec[i]) begin
                w_cnt_next[i] = r_cnt[i] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || new_game) begin
            r_cnt  <= '0;
            r_lost <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (|w_drop) begin
                r_lost <= 1'b1;
            end
        end
    end

    assign pend_next_any = |w_cnt_next;
    assign lost          = r_lost;

endmodule : score_event_queue
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
//  Module  : score_keeper
//  Purpose : Game score accumulator. Queues event pulses, applies one granted
//            event per cycle as a saturating add, awards gem-streak bonuses
//            and strobes extra_life each time a life threshold is crossed.
//  Ports   : clk, rst_n (sync, active low), new_game (sync clear)
//            ev_gem / ev_gold / ev_enemy / ev_death - event pulses
//            score      - binary score 0..MAX_SCORE
//            extra_life - one-cycle strobe on crossing a life threshold
//            busy       - any event or bonus pending
//            saturated  - sticky, score reached MAX_SCORE
//            lost       - sticky, an event pulse was dropped
//  Revision: 1.0 - initial release
// ============================================================================
module score_keeper
    import score_pkg::*;
#(
    parameter int PTS_GEM    = PTS_GEM_DEF,
    parameter int PTS_GOLD   = PTS_GOLD_DEF,
    parameter int PTS_ENEMY  = PTS_ENEMY_DEF,
    parameter int PTS_STREAK = PTS_STREAK_DEF,
    parameter int STREAK_LEN = STREAK_LEN_DEF,
    parameter int LIFE_STEP  = LIFE_STEP_DEF,
    parameter int MAX_SCORE  = MAX_SCORE_DEF
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               new_game,
    input  logic               ev_gem,
    input  logic               ev_gold,
    input  logic               ev_enemy,
    input  logic               ev_death,
    output logic [SCORE_W-1:0] score,
    output logic               extra_life,
    output logic               busy,
    output logic               saturated,
    output logic               lost
);

    localparam int C_STREAK_W = $clog2(STREAK_LEN + 1);

    ev_type_t              w_grant;
    logic                  w_pend_next_any;
    logic                  w_apply;
    logic [SCORE_W-1:0]    w_pts;
    logic [SCORE_W:0]      w_sum;
    logic [SCORE_W-1:0]    w_new_score;
    logic                  w_life_hit;
    logic                  w_streak_done;
    logic [C_STREAK_W-1:0] w_streak_next;
    logic                  w_bonus_next;

    logic [SCORE_W-1:0]    r_score;
    logic [SCORE_W-1:0]    r_next_life;
    logic [C_STREAK_W-1:0] r_streak;
    logic                  r_bonus;
    logic                  r_extra_life;
    logic                  r_busy;
    logic                  r_saturated;

    score_event_queue u_queue (
        .clk           (clk),
        .rst_n         (rst_n),
        .new_game      (new_game),
        .ev_gem        (ev_gem),
        .ev_gold       (ev_gold),
        .ev_enemy      (ev_enemy),
        .bonus_pending (r_bonus),
        .grant         (w_grant),
        .pend_next_any (w_pend_next_any),
        .lost          (lost)
    );

    always_comb begin
        w_pts = '0;
        case (w_grant)
            EV_GEM:   w_pts = SCORE_W'(PTS_GEM);
            EV_GOLD:  w_pts = SCORE_W'(PTS_GOLD);
            EV_ENEMY: w_pts = SCORE_W'(PTS_ENEMY);
            EV_BONUS: w_pts = SCORE_W'(PTS_STREAK);
            default:  w_pts = '0;
        endcase
    end

    // One extra sum bit keeps the add from wrapping before the clamp.
    assign w_apply     = (w_grant != EV_NONE);
    assign w_sum       = {1'b0, r_score} + {1'b0, w_pts};
    assign w_new_score = (w_sum >= (SCORE_W + 1)'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE)
                                                             : w_sum[SCORE_W-1:0];

    // Thresholds beyond the display ceiling can never be reached, so the
    // strobe stops once next_life walks past MAX_SCORE.
    assign w_life_hit = w_apply
                     && (w_new_score >= r_next_life)
                     && (r_next_life <= SCORE_W'(MAX_SCORE));

    // A death in the same cycle as a gem grant clears the streak and also
    // suppresses the bonus that gem would otherwise have completed.
    assign w_streak_done = (w_grant == EV_GEM) && !ev_death
                        && (r_streak == C_STREAK_W'(STREAK_LEN - 1));

    always_comb begin
        w_streak_next = r_streak;
        if (ev_death) begin
            w_streak_next = '0;
        end else if (w_grant == EV_GEM) begin
            w_streak_next = w_streak_done ? '0 : r_streak + C_STREAK_W'(1);
        end
    end

    always_comb begin
        w_bonus_next = r_bonus;
        if (w_grant == EV_BONUS) begin
            w_bonus_next = 1'b0;
        end else if (w_streak_done) begin
            w_bonus_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || new_game) begin
            r_score      <= '0;
            r_next_life  <= SCORE_W'(LIFE_STEP);
            r_streak     <= '0;
            r_bonus      <= 1'b0;
            r_extra_life <= 1'b0;
            r_busy       <= 1'b0;
            r_saturated  <= 1'b0;
        end else begin
            r_extra_life <= 1'b0;
            if (w_apply) begin
                r_score <= w_new_score;
                if (w_new_score == SCORE_W'(MAX_SCORE)) begin
                    r_saturated <= 1'b1;
                end
                if (w_life_hit) begin
                    r_extra_life <= 1'b1;
                    r_next_life  <= r_next_life + SCORE_W'(LIFE_STEP);
                end
            end
            r_streak <= w_streak_next;
            r_bonus  <= w_bonus_next;
            r_busy   <= w_pend_next_any | w_bonus_next;
        end
    end

    assign score      = r_score;
    assign extra_life = r_extra_life;
    assign busy       = r_busy;
    assign saturated  = r_saturated;

endmodule : score_keeper
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module  : tb_score_keeper
//  Purpose : Directed self-checking bench for score_keeper. Inputs change one
//            time unit after the rising edge; outputs are checked there too,
//            so each check sees the state left by the preceding edge.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_score_keeper;

    logic        clk;
    logic        rst_n;
    logic        new_game;
    logic        ev_gem;
    logic        ev_gold;
    logic        ev_enemy;
    logic        ev_death;
    logic [15:0] score;
    logic        extra_life;
    logic        busy;
    logic        saturated;
    logic        lost;

    int n_checks;
    int n_fail;
    int life_cnt;
    int wrap_err;
    int l0;

    score_keeper dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_game   (new_game),
        .ev_gem     (ev_gem),
        .ev_gold    (ev_gold),
        .ev_enemy   (ev_enemy),
        .ev_death   (ev_death),
        .score      (score),
        .extra_life (extra_life),
        .busy       (busy),
        .saturated  (saturated),
        .lost       (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe counter and out-of-range watch, sampled mid-cycle.
    always @(negedge clk) begin
        if (extra_life === 1'b1) life_cnt++;
        if (score > 16'd999) wrap_err++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; life_cnt = 0; wrap_err = 0;
        rst_n = 1'b0; new_game = 1'b0;
        ev_gem = 1'b0; ev_gold = 1'b0; ev_enemy = 1'b0; ev_death = 1'b0;
        tick(); tick();
        check("rst_score", score, 0);
        check("rst_busy", busy, 0);
        check("rst_sat", saturated, 0);
        check("rst_lost", lost, 0);
        check("rst_xlife", extra_life, 0);
        rst_n = 1'b1;
        tick();

        // Single gold event: two edges to reach the score.
        l0 = life_cnt;
        ev_gold = 1'b1; tick(); ev_gold = 1'b0;
        check("gold_busy1", busy, 1);
        check("gold_score0", score, 0);
        tick();
        check("gold_score5", score, 5);
        check("gold_busy0", busy, 0);
        tick();
        check("gold_nolife", life_cnt - l0, 0);

        // Simultaneous events drain enemy, gold, gem.
        clear_game();
        ev_gem = 1'b1; ev_gold = 1'b1; ev_enemy = 1'b1; tick();
        ev_gem = 1'b0; ev_gold = 1'b0; ev_enemy = 1'b0;
        check("tri_busy", busy, 1);
        tick(); check("tri_s10", score, 10);
        tick(); check("tri_s15", score, 15);
        check("tri_busy_mid", busy, 1);
        tick(); check("tri_s16", score, 16);
        check("tri_busy_end", busy, 0);

        // Eight spaced gems earn the streak bonus.
        clear_game();
        for (int i = 0; i < 8; i++) begin
            ev_gem = 1'b1; tick(); ev_gem = 1'b0;
            tick();
            if (i == 7) check("streak_s8", score, 8);
            tick();
            if (i == 7) check("streak_s28", score, 28);
        end
        check("streak_busy", busy, 0);

        // Same run with a death after the fifth gem: no bonus.
        clear_game();
        for (int i = 0; i < 8; i++) begin
            ev_gem = 1'b1; tick(); ev_gem = 1'b0;
            tick();
            if (i == 4) ev_death = 1'b1;
            tick();
            ev_death = 1'b0;
        end
        tick(); tick();
        check("death_s8", score, 8);
        check("death_busy", busy, 0);

        // Life thresholds at 100 and 200.
        clear_game();
        l0 = life_cnt;
        ev_enemy = 1'b1; repeat (9) tick(); ev_enemy = 1'b0;
        ev_gold = 1'b1; tick(); ev_gold = 1'b0;
        repeat (4) tick();
        check("life_s95", score, 95);
        check("life_none95", life_cnt - l0, 0);
        ev_enemy = 1'b1; tick(); ev_enemy = 1'b0;
        tick();
        check("life_s105", score, 105);
        check("life_strobe1", extra_life, 1);
        tick();
        check("life_strobe1_off", extra_life, 0);
        check("life_cnt1", life_cnt - l0, 1);
        ev_enemy = 1'b1; repeat (9) tick(); ev_enemy = 1'b0;
        ev_gem = 1'b1; repeat (4) tick(); ev_gem = 1'b0;
        repeat (4) tick();
        check("life_s199", score, 199);
        check("life_cnt199", life_cnt - l0, 1);
        ev_gem = 1'b1; tick(); ev_gem = 1'b0;
        tick();
        check("life_s200", score, 200);
        check("life_strobe2", extra_life, 1);
        tick();
        check("life_cnt2", life_cnt - l0, 2);

        // Continuous enemies saturate at 999 with nine strobes.
        clear_game();
        l0 = life_cnt;
        ev_enemy = 1'b1; repeat (105) tick(); ev_enemy = 1'b0;
        repeat (3) tick();
        check("sat_score", score, 999);
        check("sat_flag", saturated, 1);
        check("sat_lives", life_cnt - l0, 9);
        check("sat_nowrap", wrap_err, 0);

        // Overfill gold/gem behind a steady enemy stream.
        ev_enemy = 1'b1; ev_gold = 1'b1; ev_gem = 1'b1;
        repeat (8) tick();
        ev_enemy = 1'b0; ev_gold = 1'b0;
        check("lost_set", lost, 1);
        check("lost_busy", busy, 1);
        check("lost_score", score, 999);

        // new_game with pending work and a coincident gem pulse.
        new_game = 1'b1; tick(); new_game = 1'b0; ev_gem = 1'b0;
        check("ng_score", score, 0);
        check("ng_busy", busy, 0);
        check("ng_lost", lost, 0);
        check("ng_sat", saturated, 0);
        tick();
        check("ng_gem_drop_busy", busy, 0);
        check("ng_gem_drop_score", score, 0);

        // Reset with pending work and a coincident gem pulse.
        ev_gold = 1'b1; ev_enemy = 1'b1; tick(); tick();
        ev_gold = 1'b0; ev_enemy = 1'b0;
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0; ev_gem = 1'b1; tick();
        rst_n = 1'b1; ev_gem = 1'b0;
        check("rst2_score", score, 0);
        check("rst2_busy", busy, 0);
        tick();
        check("rst2_gem_drop_busy", busy, 0);
        check("rst2_gem_drop_score", score, 0);
        check("final_nowrap", wrap_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_score_keeper
`default_nettype wire
